spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 65 ++++++
 tb/tb_spi_reg_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-framed 8x8 register bank with command decode, burst write/read and message counter
module spi_reg_bank (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       cs_start,
   input  logic       cs_end,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       cmd_err,
   output logic       led,
   output logic [7:0] cfg_a,
   output logic [7:0] cfg_b
);
   typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;
   state_t state, state_nx;
   logic [2:0] addr, addr_nx;
   logic [7:0] msg_cnt;
   logic [7:0] rw [2:7];
   logic [7:0] map [8];
   logic byte_ok, wr;
   always_comb begin
      byte_ok = rx_valid && !cs_start;
      wr = byte_ok && state == WRITE && addr >= 3'd2;
      addr_nx = addr;
      state_nx = state;
      case (state)
         CMD: if (byte_ok) begin
            if (rx_data[6:3] == 4'd0) begin
               addr_nx = rx_data[2:0];
               state_nx = rx_data[7] ? READ : WRITE;
            end else state_nx = IGNORE;
         end
         WRITE, READ: if (byte_ok) addr_nx = addr + 3'd1;
         default: ;
      endcase
      if (cs_start) state_nx = CMD;
      if (cs_end) state_nx = IDLE;
      map[0] = 8'hA5;
      map[1] = msg_cnt;
      for (int i = 2; i < 8; i++) map[i] = rw[i];
   end
   // tx_data looks ahead at next state/address so it lands one cycle after the byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         addr <= 3'd0;
         msg_cnt <= 8'h00;
         tx_data <= 8'h00;
         for (int i = 2; i < 8; i++) rw[i] <= 8'h00;
      end else begin
         state <= state_nx;
         addr <= addr_nx;
         msg_cnt <= msg_cnt + {7'd0, cs_end};
         tx_data <= state_nx == READ ? map[addr_nx] : 8'h00;
         for (int i = 2; i < 8; i++) if (wr && addr == 3'(i)) rw[i] <= rx_data;
      end
   end
   assign busy = state != IDLE;
   assign cmd_err = state == IGNORE;
   assign led = rw[2][0];
   assign cfg_a = rw[3];
   assign cfg_b = rw[4];
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed scoreboard bench for spi_reg_bank
module tb_spi_reg_bank;
   logic clk = 0, rst = 0, rx_valid = 0, cs_start = 0, cs_end = 0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] tx_data, cfg_a, cfg_b;
   logic busy, cmd_err, led;
   int n_chk = 0, n_err = 0;
   logic [7:0] sb [$];
   logic [7:0] m_cnt = 8'h00;

   spi_reg_bank dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .cs_start(cs_start), .cs_end(cs_end), .tx_data(tx_data), .busy(busy),
      .cmd_err(cmd_err), .led(led), .cfg_a(cfg_a), .cfg_b(cfg_b)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      sb.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs);
      logic [7:0] e;
      n_chk++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic start;
      cs_start = 1;
      tick;
      cs_start = 0;
   endtask

   task automatic stop;
      cs_end = 1;
      tick;
      cs_end = 0;
      m_cnt++;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1;
      rx_data = b;
      tick;
      rx_valid = 0;
      rx_data = 8'h00;
   endtask

   initial begin
      #1 rst = 1;
      #1;
      push(8'h00); chk("rst_tx", tx_data);
      push(8'h00); chk("rst_busy", {7'd0, busy});
      push(8'h00); chk("rst_cmd_err", {7'd0, cmd_err});
      push(8'h00); chk("rst_led", {7'd0, led});
      push(8'h00); chk("rst_cfg_a", cfg_a);
      push(8'h00); chk("rst_cfg_b", cfg_b);
      tick;
      rst = 0;
      tick;
      // write burst into CFG_A/CFG_B
      start;
      send(8'h03);
      push(8'h01); chk("wr_busy_mid", {7'd0, busy});
      send(8'h5A);
      send(8'hC3);
      stop;
      push(8'h5A); chk("wr_cfg_a", cfg_a);
      push(8'hC3); chk("wr_cfg_b", cfg_b);
      push(8'h00); chk("wr_busy_end", {7'd0, busy});
      start;
      stop;
      // read burst wrapping 7 -> 0 -> 1
      start;
      push(8'h00); send(8'h87); chk("rd_reg7", tx_data);
      push(8'hA5); send(8'h11); chk("rd_reg0", tx_data);
      push(8'h02); send(8'h22); chk("rd_reg1", tx_data);
      stop;
      push(8'h00); chk("rd_idle_tx", tx_data);
      push(8'h00); chk("rd_idle_busy", {7'd0, busy});
      // writes to read-only addresses are dropped
      start;
      send(8'h00);
      send(8'h11);
      send(8'h22);
      stop;
      push(8'h00); chk("ro_led", {7'd0, led});
      start;
      push(8'hA5); send(8'h80); chk("ro_id", tx_data);
      push(m_cnt); send(8'h00); chk("ro_msg_cnt", tx_data);
      push(8'h00); send(8'h00); chk("ro_reg2", tx_data);
      stop;
      // malformed command
      start;
      send(8'h48);
      push(8'h01); chk("bad_cmd_err", {7'd0, cmd_err});
      push(8'h00); chk("bad_tx", tx_data);
      send(8'hFF);
      push(8'h01); chk("bad_cmd_err2", {7'd0, cmd_err});
      push(8'h00); chk("bad_tx2", tx_data);
      push(8'h5A); chk("bad_cfg_a", cfg_a);
      stop;
      push(8'h00); chk("bad_cmd_err_end", {7'd0, cmd_err});
      // last byte coincident with cs_end, then start+end together
      start;
      send(8'h02);
      rx_valid = 1; rx_data = 8'h01; cs_end = 1;
      tick;
      rx_valid = 0; rx_data = 8'h00; cs_end = 0;
      m_cnt++;
      push(8'h01); chk("sim_led", {7'd0, led});
      push(8'h00); chk("sim_busy", {7'd0, busy});
      cs_start = 1; cs_end = 1;
      tick;
      cs_start = 0; cs_end = 0;
      m_cnt++;
      push(8'h00); chk("sim_se_busy", {7'd0, busy});
      start;
      push(m_cnt); send(8'h81); chk("sim_msg_cnt", tx_data);
      stop;
      // cs_start with rx_valid: byte dropped, restart to CMD
      start;
      send(8'h03);
      cs_start = 1; rx_valid = 1; rx_data = 8'h77;
      tick;
      cs_start = 0; rx_valid = 0; rx_data = 8'h00;
      push(8'h01); chk("rs_busy", {7'd0, busy});
      push(8'h5A); chk("rs_cfg_a", cfg_a);
      push(8'h5A); send(8'h83); chk("rs_rd_cfg_a", tx_data);
      stop;
      start;
      push(m_cnt); send(8'h81); chk("rs_msg_cnt", tx_data);
      stop;
      // reset mid-write
      start;
      send(8'h02);
      rst = 1;
      #1;
      m_cnt = 8'h00;
      push(8'h00); chk("mr_busy", {7'd0, busy});
      push(8'h00); chk("mr_led", {7'd0, led});
      push(8'h00); chk("mr_cfg_a", cfg_a);
      tick;
      rst = 0;
      send(8'hFF);
      push(8'h00); chk("mr_led_after", {7'd0, led});
      push(8'h00); chk("mr_busy_after", {7'd0, busy});
      for (int i = 0; i < 255; i++) stop;
      start;
      push(m_cnt); send(8'h81); chk("cnt_ff", tx_data);
      stop;
      start;
      push(m_cnt); send(8'h81); chk("cnt_wrap", tx_data);
      stop;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
